dmem_arbiter: RTL and testbench

- Sequences all accesses to the single-port data memory (`data_mem`) of the RISC-V pipeline.
- Shares that memory between two requesters: the MEM stage of the core and a debug/loader port. The loader port preloads arrays and reads back results.
- Owns the RAM enable/write/address pins and produces the pipeline stall for the MEM stage.
- Implements fixed CPU priority with a starvation guard for the debug port.

---
 rtl/dmem_arbiter.sv | 98 +++++++++
 tb/tb_dmem_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the MEM stage (CPU) and a debug/loader port.
// Ports:
//   clock, reset                  - rising-edge clock, synchronous active-low reset
//   i_cpu_req/we/addr/wdata       - MEM-stage request, held until o_cpu_ack
//   o_cpu_rdata/ack/err/stall     - CPU response pulse and pipeline stall
//   i_dbg_req/we/addr/wdata       - debug/loader request, same handshake as the CPU
//   o_dbg_rdata/ack/err           - debug response pulse
//   o_mem_en/we/addr/wdata        - RAM strobe, write enable, word address, write data
//   i_mem_rdata                   - RAM read data, valid the cycle after o_mem_en
module dmem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [31:0]       i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_ack,
  output logic              o_cpu_err,
  output logic              o_cpu_stall,
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic [31:0]       i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic [DATA_W-1:0] o_dbg_rdata,
  output logic              o_dbg_ack,
  output logic              o_dbg_err,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, ERRCHK, RESP} state_t;
  state_t              r_state, w_next;
  logic [CW-1:0]       r_starve_cnt;
  logic                r_owner, r_we, r_err;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                w_any, w_dbg_prio, w_cpu_win, w_dbg_win, w_req_we, w_bad, w_resp;
  logic [31:0]         w_req_addr;
  logic [DATA_W-1:0]   w_req_wdata, w_resp_data;
  assign w_any       = i_cpu_req | i_dbg_req;
  assign w_dbg_prio  = r_starve_cnt == CW'(STARVE_MAX);
  assign w_cpu_win   = i_cpu_req & ~(i_dbg_req & w_dbg_prio);
  assign w_dbg_win   = i_dbg_req & ~w_cpu_win;
  assign w_req_we    = w_dbg_win ? i_dbg_we : i_cpu_we;
  assign w_req_addr  = w_dbg_win ? i_dbg_addr : i_cpu_addr;
  assign w_req_wdata = w_dbg_win ? i_dbg_wdata : i_cpu_wdata;
  // misaligned or beyond the 2^ADDR_W-word RAM
  assign w_bad       = (w_req_addr[1:0] != 2'b00) | ((w_req_addr >> (ADDR_W + 2)) != 32'd0);
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_owner <= w_dbg_win;
        r_we    <= w_req_we;
        r_err   <= w_bad;
        r_addr  <= w_req_addr[ADDR_W+1:2];
        r_wdata <= w_req_wdata;
      end
      // counts CPU wins over a waiting debug request; cleared once debug is served or stops asking
      if (r_state == IDLE)
        r_starve_cnt <= (!i_dbg_req || w_dbg_win) ? '0 : w_dbg_prio ? r_starve_cnt : r_starve_cnt + CW'(1);
    end
  end
  always_comb begin
    w_next      = IDLE;
    w_next      = (r_state == IDLE) ? (w_any ? (w_bad ? ERRCHK : ACCESS) : IDLE) :
                  (r_state == RESP) ? IDLE : RESP;
    w_resp      = r_state == RESP;
    w_resp_data = (r_we | r_err) ? '0 : i_mem_rdata;
    o_cpu_ack   = w_resp & ~r_owner;
    o_dbg_ack   = w_resp & r_owner;
    o_cpu_rdata = o_cpu_ack ? w_resp_data : '0;
    o_dbg_rdata = o_dbg_ack ? w_resp_data : '0;
    o_cpu_err   = o_cpu_ack & r_err;
    o_dbg_err   = o_dbg_ack & r_err;
    o_cpu_stall = i_cpu_req & ~o_cpu_ack;
    o_mem_en    = r_state == ACCESS;
    o_mem_we    = o_mem_en & r_we;
    o_mem_addr  = o_mem_en ? r_addr : '0;
    o_mem_wdata = o_mem_en ? r_wdata : '0;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed check of dmem_arbiter against a transaction-level model.
module tb_dmem_arbiter;
  logic        clock = 1'b0, reset = 1'b0;
  logic        cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dbg_addr = 0, dbg_wdata = 0;
  logic [31:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic        cpu_ack, cpu_err, cpu_stall, dbg_ack, dbg_err, mem_en, mem_we;
  logic [7:0]  mem_addr;
  int          n_chk = 0, n_fail = 0, wr_cnt = 0, en_cnt = 0;
  always #5 clock = ~clock;
  dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clock(clock), .reset(reset),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata), .o_cpu_ack(cpu_ack), .o_cpu_err(cpu_err), .o_cpu_stall(cpu_stall),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_dbg_rdata(dbg_rdata), .o_dbg_ack(dbg_ack), .o_dbg_err(dbg_err),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata));
  // synchronous single-port RAM
  logic [31:0] ram [256];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 0;
    mem_rdata = 0;
  end
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
      en_cnt <= en_cnt + 1;
      if (mem_we) wr_cnt <= wr_cnt + 1;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // transaction-level model: one transaction in flight, scheduled by cycle number
  logic [31:0] shadow [256];
  initial for (int i = 0; i < 256; i++) shadow[i] = 0;
  int          cyc = 0, next_arb = 0, starve = 0, g = 0;
  bit          init = 0, p_valid = 0, p_owner = 0, p_we = 0, p_err = 0;
  logic [31:0] p_addr = 0, p_wdata = 0, p_rdata = 0;
  always @(posedge clock) begin
    bit dw;
    cyc++;
    if (p_valid && cyc == g + 1 && !p_err) begin
      if (p_we) shadow[p_addr[9:2]] = p_wdata;
      else p_rdata = shadow[p_addr[9:2]];
    end
    if (!reset) begin
      init = 1; p_valid = 0; starve = 0; next_arb = cyc + 1;
    end else if (init && cyc >= next_arb) begin
      dw = dbg_req && (!cpu_req || starve == 4);
      if (cpu_req || dbg_req) begin
        p_valid = 1; g = cyc; next_arb = cyc + 3; p_owner = dw;
        p_we    = dw ? dbg_we : cpu_we;
        p_addr  = dw ? dbg_addr : cpu_addr;
        p_wdata = dw ? dbg_wdata : cpu_wdata;
        p_err   = p_addr[1:0] != 0 || p_addr >= 32'd1024;
      end
      if (!dbg_req || dw) starve = 0;
      else if (starve < 4) starve++;
    end
  end
  always @(negedge clock) begin
    bit acc, rsp, ca, da;
    logic [31:0] rd;
    if (init) begin
      acc = p_valid && cyc == g && !p_err;
      rsp = p_valid && cyc == g + 1;
      ca  = rsp && !p_owner;
      da  = rsp && p_owner;
      rd  = (p_err || p_we) ? 32'd0 : p_rdata;
      chk("mem_en", mem_en, acc);
      chk("mem_we", mem_we, acc && p_we);
      chk("mem_addr", mem_addr, acc ? p_addr[9:2] : 0);
      chk("mem_wdata", mem_wdata, acc ? p_wdata : 0);
      chk("cpu_ack", cpu_ack, ca);
      chk("cpu_rdata", cpu_rdata, ca ? rd : 0);
      chk("cpu_err", cpu_err, ca && p_err);
      chk("cpu_stall", cpu_stall, cpu_req && !ca);
      chk("dbg_ack", dbg_ack, da);
      chk("dbg_rdata", dbg_rdata, da ? rd : 0);
      chk("dbg_err", dbg_err, da && p_err);
    end
  end
  // requesters: called at posedge+1, return at posedge+1 after the ack edge; n = cycles until ack
  task automatic cpu_xfer(input logic we, input logic [31:0] a, d, output logic [31:0] rd, output logic er, output int n);
    bit got = 0;
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; n = 0; rd = 0; er = 0;
    while (!got && n < 60) begin
      @(negedge clock); n++;
      if (cpu_ack) begin got = 1; rd = cpu_rdata; er = cpu_err; end
    end
    chk("cpu_timeout", got, 1);
    @(posedge clock); #1;
    cpu_req = 0;
  endtask
  task automatic dbg_xfer(input logic we, input logic [31:0] a, d, output logic [31:0] rd, output logic er, output int n);
    bit got = 0;
    dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = d; n = 0; rd = 0; er = 0;
    while (!got && n < 60) begin
      @(negedge clock); n++;
      if (dbg_ack) begin got = 1; rd = dbg_rdata; er = dbg_err; end
    end
    chk("dbg_timeout", got, 1);
    @(posedge clock); #1;
    dbg_req = 0;
  endtask
  task automatic idle(input int k);
    repeat (k) begin @(posedge clock); #1; end
  endtask
  function automatic logic [31:0] rnd_addr();
    int r = $urandom_range(0, 9);
    logic [31:0] w = 32'($urandom_range(0, 255)) << 2;
    return r == 0 ? w | 32'($urandom_range(1, 3)) : r == 1 ? 32'h400 << $urandom_range(0, 21) : w;
  endfunction
  initial begin
    logic [31:0] rd, rd2, vals [4];
    logic        er, er2;
    int          n, n2, w0, e0;
    vals[0] = 42; vals[1] = 17; vals[2] = 93; vals[3] = 58;
    repeat (3) @(posedge clock);
    #1 reset = 1;
    idle(1);
    chk("rst_stall", cpu_stall, 0);
    for (int i = 0; i < 4; i++) begin
      dbg_xfer(1, 32'(i * 4), vals[i], rd, er, n);
      chk("pre_lat", n, 3);
      chk("pre_err", er, 0);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_xfer(0, 32'(i * 4), 0, rd, er, n);
      chk("rb_data", rd, vals[i]);
    end
    cpu_xfer(0, 8, 0, rd, er, n);
    chk("lw8_data", rd, 93);
    chk("lw8_stall_cycles", n - 1, 2);
    fork
      begin cpu_xfer(0, 12, 0, rd, er, n); chk("col_cpu_lat", n, 3); end
      begin dbg_xfer(0, 4, 0, rd2, er2, n2); chk("col_dbg_lat", n2, 6); chk("col_dbg_data", rd2, 17); end
    join
    idle(1);
    fork
      repeat (5) cpu_xfer(0, 8, 0, rd, er, n);
      begin dbg_xfer(0, 0, 0, rd2, er2, n2); chk("starve_lat", n2, 15); end
    join
    idle(1);
    e0 = en_cnt;
    cpu_xfer(1, 6, 32'hdead, rd, er, n);
    chk("mis_err", er, 1);
    chk("mis_rdata", rd, 0);
    cpu_xfer(1, 1024, 32'hbeef, rd, er, n);
    chk("oor_err", er, 1);
    chk("oor_rdata", rd, 0);
    chk("err_no_mem_en", en_cnt, e0);
    cpu_xfer(0, 4, 0, rd, er, n);
    chk("mis_unchanged", rd, 17);
    cpu_xfer(0, 0, 0, rd, er, n);
    chk("oor_unchanged", rd, 42);
    cpu_req = 1; cpu_we = 0; cpu_addr = 8;
    @(posedge clock); #1;
    reset = 0;
    @(posedge clock); #1;
    @(negedge clock);
    chk("rst_ack", cpu_ack, 0);
    chk("rst_mem_en", mem_en, 0);
    cpu_req = 0; reset = 1;
    @(posedge clock); #1;
    cpu_xfer(0, 0, 0, rd, er, n);
    chk("post_rst_data", rd, 42);
    w0 = wr_cnt;
    cpu_xfer(1, 4, 5, rd, er, n);
    cpu_xfer(0, 4, 0, rd, er, n);
    chk("b2b_data", rd, 5);
    chk("b2b_lat", n, 3);
    chk("b2b_one_write", wr_cnt - w0, 1);
    fork
      repeat (40) begin idle($urandom_range(0, 3)); cpu_xfer(1'($urandom_range(0, 1)), rnd_addr(), $urandom, rd, er, n); end
      repeat (25) begin idle($urandom_range(0, 4)); dbg_xfer(1'($urandom_range(0, 1)), rnd_addr(), $urandom, rd2, er2, n2); end
    join
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
